// File: rtl/axi_wr_responder_if.sv
// AXI3-style write-channel bundle (AW, W, B) between a bus master and a
// write responder. The master modport drives requests and data; the slave
// modport drives the ready signals and the B response.
interface axi_wr_responder_if;
  logic [3:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [3:0]  WID;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_wr_responder.sv
// AXI3-style write responder: accepts one AW burst at a time, writes the
// beats into a local 32-bit word RAM and returns a B response.
// Ports:
//   clk        clock, all logic on posedge
//   rst_n      synchronous active-low reset
//   bus        AW/W/B channels (slave side)
//   dbg_addr   RAM word index for the debug read port
//   dbg_rdata  RAM[dbg_addr], registered, one cycle latency
//
// state | meaning
// IDLE  | waiting for AW handshake (AWREADY high once out of reset)
// DATA  | accepting W beats until beat_cnt reaches the latched length
// RESP  | holding BVALID/BID/BRESP until BREADY
module axi_wr_responder #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axi_wr_responder_if.slave            bus,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [31:0]                  dbg_rdata
);
  localparam int AW = $clog2(MEM_WORDS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

  state_t      state, state_nx;
  logic        active;
  logic        awready, wready, bvalid;
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [3:0]  len_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic [3:0]  beat_cnt;
  logic [1:0]  err_q;
  logic        nowr_q;

  logic [31:0] mem [MEM_WORDS];

  logic        cfg_err;
  logic        borrow;
  logic [29:0] woff;
  logic        dec_err;
  logic        slv_beat;
  logic        last_beat;
  logic [31:0] step;
  logic [31:0] wmask;
  logic [31:0] addr_nx;
  logic        mem_we;

  // Burst shapes the RAM cannot honour are flagged at AW time and
  // suppress every write of the burst.
  always_comb begin
    cfg_err = (bus.AWSIZE > 3'd2) || (bus.AWBURST == 2'b11);
    if (bus.AWBURST == 2'b10 && !(bus.AWLEN == 4'd1 || bus.AWLEN == 4'd3 ||
                                  bus.AWLEN == 4'd7 || bus.AWLEN == 4'd15))
      cfg_err = 1'b1;
  end

  // Word offset from the base; the borrow bit catches addresses below it.
  assign {borrow, woff} = {1'b0, addr_q[31:2]} - {1'b0, BASE_ADDR[31:2]};
  assign dec_err   = borrow || (|woff[29:AW]);
  assign last_beat = (beat_cnt == len_q);
  assign slv_beat  = (bus.WLAST != last_beat) || (bus.WID != id_q);
  assign step      = 32'd1 << size_q;
  assign wmask     = (({28'd0, len_q} + 32'd1) << size_q) - 32'd1;
  assign mem_we    = wready && bus.WVALID && !nowr_q && !dec_err;

  always_comb begin
    case (burst_q)
      2'b00:   addr_nx = addr_q;
      2'b10:   addr_nx = (addr_q & ~wmask) | ((addr_q + step) & wmask);
      default: addr_nx = addr_q + step;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      active <= 1'b0;
    end else begin
      state  <= state_nx;
      active <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    awready  = 1'b0;
    wready   = 1'b0;
    bvalid   = 1'b0;
    case (state)
      IDLE: begin
        awready = active;
        if (active && bus.AWVALID) state_nx = DATA;
      end
      DATA: begin
        wready = 1'b1;
        if (bus.WVALID && last_beat) state_nx = RESP;
      end
      RESP: begin
        bvalid = 1'b1;
        if (bus.BREADY) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      size_q   <= '0;
      burst_q  <= '0;
      beat_cnt <= '0;
      err_q    <= RESP_OKAY;
      nowr_q   <= 1'b0;
    end else if (awready && bus.AWVALID) begin
      id_q     <= bus.AWID;
      addr_q   <= bus.AWADDR;
      len_q    <= bus.AWLEN;
      size_q   <= bus.AWSIZE;
      burst_q  <= bus.AWBURST;
      beat_cnt <= '0;
      err_q    <= cfg_err ? RESP_SLVERR : RESP_OKAY;
      nowr_q   <= cfg_err;
    end else if (wready && bus.WVALID) begin
      beat_cnt <= beat_cnt + 4'd1;
      addr_q   <= addr_nx;
      if (dec_err)
        err_q <= RESP_DECERR;
      else if (slv_beat && err_q != RESP_DECERR)
        err_q <= RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (mem_we && bus.WSTRB[i])
        mem[woff[AW-1:0]][8*i +: 8] <= bus.WDATA[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) dbg_rdata <= '0;
    else        dbg_rdata <= mem[dbg_addr];
  end

  assign bus.AWREADY = awready;
  assign bus.WREADY  = wready;
  assign bus.BVALID  = bvalid;
  assign bus.BID     = id_q;
  assign bus.BRESP   = err_q;
endmodule

// File: tb/tb_axi_wr_responder.sv
module tb_axi_wr_responder;
  logic        clk;
  logic        rst_n;
  logic [7:0]  dbg_addr;
  logic [31:0] dbg_rdata;
  int checks = 0;
  int errors = 0;

  axi_wr_responder_if bus ();

  axi_wr_responder #(.MEM_WORDS(256), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int n;
    @(negedge clk);
    bus.AWID = id; bus.AWADDR = addr; bus.AWLEN = len;
    bus.AWSIZE = size; bus.AWBURST = burst; bus.AWVALID = 1'b1;
    n = 0;
    while (bus.AWREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("aw_ready", {31'd0, bus.AWREADY}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.AWVALID = 1'b0;
  endtask

  task automatic do_w(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                      input logic last);
    int n;
    bus.WID = id; bus.WDATA = data; bus.WSTRB = strb; bus.WLAST = last; bus.WVALID = 1'b1;
    n = 0;
    while (bus.WREADY !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("w_ready", {31'd0, bus.WREADY}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.WVALID = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    int n;
    bus.BREADY = 1'b1;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("b_valid", {31'd0, bus.BVALID}, 32'd1);
    check("b_id", {28'd0, bus.BID}, {28'd0, id});
    check("b_resp", {30'd0, bus.BRESP}, {30'd0, resp});
    @(posedge clk);
    @(negedge clk);
    bus.BREADY = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic [7:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    @(negedge clk);
    check(tag, dbg_rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; dbg_addr = '0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0;
    bus.AWVALID = 1'b0; bus.WID = '0; bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0;
    bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", {31'd0, bus.AWREADY}, 32'd0);
    check("rst_wready", {31'd0, bus.WREADY}, 32'd0);
    check("rst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    check("rst_bid", {28'd0, bus.BID}, 32'd0);
    check("rst_bresp", {30'd0, bus.BRESP}, 32'd0);
    check("rst_dbg", dbg_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_awready", {31'd0, bus.AWREADY}, 32'd1);
    check("idle_wready", {31'd0, bus.WREADY}, 32'd0);

    // INCR 0x10 x4 -> words 4..7
    do_aw(4'd5, 32'h10, 4'd3, 3'd2, 2'b01);
    check("data_awready", {31'd0, bus.AWREADY}, 32'd0);
    do_w(4'd5, 32'd1, 4'hF, 1'b0);
    do_w(4'd5, 32'd2, 4'hF, 1'b0);
    do_w(4'd5, 32'd3, 4'hF, 1'b0);
    do_w(4'd5, 32'd4, 4'hF, 1'b1);
    check("b_latency", {31'd0, bus.BVALID}, 32'd1);
    check("resp_wready", {31'd0, bus.WREADY}, 32'd0);
    get_b(4'd5, 2'b00);
    chk_word("incr_w4", 8'd4, 32'd1);
    chk_word("incr_w5", 8'd5, 32'd2);
    chk_word("incr_w6", 8'd6, 32'd3);
    chk_word("incr_w7", 8'd7, 32'd4);

    // WRAP 0x38 x4 -> words 14,15,12,13
    do_aw(4'd3, 32'h38, 4'd3, 3'd2, 2'b10);
    do_w(4'd3, 32'hA, 4'hF, 1'b0);
    do_w(4'd3, 32'hB, 4'hF, 1'b0);
    do_w(4'd3, 32'hC, 4'hF, 1'b0);
    do_w(4'd3, 32'hD, 4'hF, 1'b1);
    get_b(4'd3, 2'b00);
    chk_word("wrap_w14", 8'd14, 32'hA);
    chk_word("wrap_w15", 8'd15, 32'hB);
    chk_word("wrap_w12", 8'd12, 32'hC);
    chk_word("wrap_w13", 8'd13, 32'hD);

    // FIXED with lane strobes -> word 8 merged
    do_aw(4'd1, 32'h20, 4'd1, 3'd2, 2'b00);
    do_w(4'd1, 32'h1111_2222, 4'h3, 1'b0);
    do_w(4'd1, 32'h3333_4444, 4'hC, 1'b1);
    get_b(4'd1, 2'b00);
    chk_word("fixed_w8", 8'd8, 32'h3333_2222);

    // Last RAM word then out of range -> DECERR
    do_aw(4'd6, 32'h3FC, 4'd1, 3'd2, 2'b01);
    do_w(4'd6, 32'hDEAD_0001, 4'hF, 1'b0);
    do_w(4'd6, 32'hDEAD_0002, 4'hF, 1'b1);
    get_b(4'd6, 2'b11);
    chk_word("dec_w255", 8'd255, 32'hDEAD_0001);

    // Early WLAST -> both beats written, SLVERR; BREADY held off
    do_aw(4'd7, 32'h40, 4'd1, 3'd2, 2'b01);
    do_w(4'd7, 32'h55, 4'hF, 1'b1);
    do_w(4'd7, 32'h66, 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_bvalid", {31'd0, bus.BVALID}, 32'd1);
      check("hold_bresp", {30'd0, bus.BRESP}, 32'd2);
      @(negedge clk);
    end
    get_b(4'd7, 2'b10);
    check("post_b_awready", {31'd0, bus.AWREADY}, 32'd1);
    check("post_b_bvalid", {31'd0, bus.BVALID}, 32'd0);
    chk_word("wlast_w16", 8'd16, 32'h55);
    chk_word("wlast_w17", 8'd17, 32'h66);

    // WID mismatch -> beat written, SLVERR
    do_aw(4'd4, 32'hB0, 4'd0, 3'd2, 2'b01);
    do_w(4'd5, 32'h44, 4'hF, 1'b1);
    get_b(4'd4, 2'b10);
    chk_word("wid_w44", 8'd44, 32'h44);

    // Reset after second beat of a 4-beat burst
    do_aw(4'd2, 32'h80, 4'd3, 3'd2, 2'b01);
    do_w(4'd2, 32'h77, 4'hF, 1'b0);
    do_w(4'd2, 32'h88, 4'hF, 1'b0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_bvalid", {31'd0, bus.BVALID}, 32'd0);
    rst_n = 1'b1;
    check("midrst_awready0", {31'd0, bus.AWREADY}, 32'd0);
    @(negedge clk);
    check("midrst_awready1", {31'd0, bus.AWREADY}, 32'd1);
    chk_word("midrst_w32", 8'd32, 32'h77);
    chk_word("midrst_w33", 8'd33, 32'h88);
    do_aw(4'd9, 32'hA0, 4'd0, 3'd2, 2'b01);
    do_w(4'd9, 32'h99, 4'hF, 1'b1);
    get_b(4'd9, 2'b00);
    chk_word("post_rst_w40", 8'd40, 32'h99);

    // Oversized AWSIZE -> SLVERR, nothing written
    do_aw(4'd1, 32'hA0, 4'd0, 3'd3, 2'b01);
    do_w(4'd1, 32'hBAD, 4'hF, 1'b1);
    get_b(4'd1, 2'b10);
    chk_word("cfg_w40", 8'd40, 32'h99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
